// File: rtl/dmem_access_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_access_pkg
//  Description : Shared types and constants for the data-memory access unit:
//                access-size codes, FSM state encoding, the pipeline stall
//                vector type and an alignment helper.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package dmem_access_pkg;

    // Access-size codes carried on req_size (2'b11 behaves as a word).
    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    // Pipeline stall vector; bit 2 holds the EX stage.
    localparam int STALL_W = 6;
    typedef logic [STALL_W-1:0] StallBus;

    localparam logic Stop   = 1'b1;
    localparam logic NoStop = 1'b0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Byte accesses are always aligned; halves need addr[0]==0 and words
    // (including the 2'b11 alias) need addr[1:0]==0.
    function automatic logic addr_aligned(input logic [1:0] size,
                                          input logic [1:0] lo);
        logic ok;
        case (size)
            SZ_B:    ok = 1'b1;
            SZ_H:    ok = ~lo[0];
            default: ok = (lo == 2'b00);
        endcase
        return ok;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_lane_align.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_lane_align
//  Description : Combinational store-lane steering. Builds the SRAM byte write
//                mask from size/address and replicates right-aligned store
//                data across all byte lanes so the mask alone picks the lane.
//  Ports       : size      in  2   access size code
//                addr_lo   in  2   byte offset within the word
//                we        in  1   1 = store (mask forced to 0 for loads)
//                wdata     in  32  right-aligned store data
//                wen       out 4   byte write mask
//                wdata_rep out 32  lane-replicated store data
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_lane_align
    import dmem_access_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic        we,
    input  logic [31:0] wdata,
    output logic [3:0]  wen,
    output logic [31:0] wdata_rep
);

    logic [3:0] mask;

    always_comb begin
        mask      = 4'b1111;
        wdata_rep = wdata;
        case (size)
            SZ_B: begin
                mask      = 4'b0001 << addr_lo;
                wdata_rep = {4{wdata[7:0]}};
            end
            SZ_H: begin
                mask      = 4'b0011 << addr_lo;
                wdata_rep = {2{wdata[15:0]}};
            end
            default: begin
                mask      = 4'b1111;
                wdata_rep = wdata;
            end
        endcase
    end

    assign wen = we ? mask : 4'b0000;

endmodule
`default_nettype wire

// File: rtl/dmem_access.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_access
//  Description : Data-memory access unit between EX and MEM. Accepts one
//                load/store per instruction, checks alignment, drives a
//                registered SRAM request, waits on ready with a timeout and
//                returns the raw read word while requesting a pipeline stall.
//  Ports       : clk, rst (async, active-low)
//                stall            in  StallBus  stall vector, bit 2 = EX
//                req_valid/we/size/addr/wdata   request from EX
//                data_sram_en/wen/addr/wdata    registered SRAM request
//                data_sram_rdata/ready          SRAM response
//                rdata_o/rdata_valid            raw read word to MEM
//                stallreq                       stall request
//                adel/ades/bus_err              one-cycle exception pulses
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_access
    import dmem_access_pkg::*;
#(
    parameter int MAX_WAIT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  StallBus     stall,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        data_sram_en,
    output logic [3:0]  data_sram_wen,
    output logic [31:0] data_sram_addr,
    output logic [31:0] data_sram_wdata,
    input  logic [31:0] data_sram_rdata,
    input  logic        data_sram_ready,
    output logic [31:0] rdata_o,
    output logic        rdata_valid,
    output logic        stallreq,
    output logic        adel,
    output logic        ades,
    output logic        bus_err
);

    localparam int              CNT_W    = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_WAIT - 1);

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic               is_store;
    logic               aligned;
    logic               stallreq_c;
    logic [3:0]         lane_wen;
    logic [31:0]        lane_wdata;

    // Only the EX bit of the stall vector matters here.
    logic               unused_stall;
    assign unused_stall = ^{stall[STALL_W-1:3], stall[1:0]};

    assign aligned = addr_aligned(req_size, req_addr[1:0]);

    dmem_lane_align u_lane_align (
        .size      (req_size),
        .addr_lo   (req_addr[1:0]),
        .we        (req_we),
        .wdata     (req_wdata),
        .wen       (lane_wen),
        .wdata_rep (lane_wdata)
    );

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next state and stall request
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt  = state;
        stallreq_c = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid && aligned) begin
                    state_nxt  = BUSY;
                    stallreq_c = 1'b1;
                end
            end
            BUSY: begin
                stallreq_c = !data_sram_ready;
                // Ready is tested first so it wins over a coincident timeout.
                if (data_sram_ready) begin
                    state_nxt = DONE;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = IDLE;
                end
            end
            DONE: begin
                if (stall[2] == NoStop) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Held low while in reset so every output reads 0 during reset.
    assign stallreq    = stallreq_c & rst;
    assign rdata_valid = (state == DONE);

    // ------------------------------------------------------------------
    // Datapath: SRAM request, wait counter, read capture, exceptions
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt             <= '0;
            is_store        <= 1'b0;
            data_sram_en    <= 1'b0;
            data_sram_wen   <= 4'b0000;
            data_sram_addr  <= 32'h0;
            data_sram_wdata <= 32'h0;
            rdata_o         <= 32'h0;
            adel            <= 1'b0;
            ades            <= 1'b0;
            bus_err         <= 1'b0;
        end else begin
            adel    <= 1'b0;
            ades    <= 1'b0;
            bus_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        if (!aligned) begin
                            adel <= !req_we;
                            ades <= req_we;
                        end else begin
                            data_sram_en    <= 1'b1;
                            data_sram_addr  <= {req_addr[31:2], 2'b00};
                            data_sram_wen   <= lane_wen;
                            data_sram_wdata <= lane_wdata;
                            is_store        <= req_we;
                            cnt             <= '0;
                        end
                    end
                end
                BUSY: begin
                    if (data_sram_ready) begin
                        data_sram_en  <= 1'b0;
                        data_sram_wen <= 4'b0000;
                        rdata_o       <= is_store ? 32'h0 : data_sram_rdata;
                    end else if (cnt == CNT_LAST) begin
                        data_sram_en  <= 1'b0;
                        data_sram_wen <= 4'b0000;
                        rdata_o       <= 32'h0;
                        bus_err       <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire
